display_scan_controller: RTL and testbench

DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

---
 rtl/display_scan_controller_pkg.sv | 24 ++
 rtl/display_scan_controller_hex7seg.sv | 36 +++
 rtl/display_scan_controller.sv | 156 +++++++++++++++
 tb/tb_display_scan_controller.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_scan_controller_pkg.sv
// Shared definitions for the multiplexed seven-segment scan controller:
// FSM encodings, segment bit positions and the all-dark output values.
package display_scan_controller_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_DRIVE = 2'd1,
    ST_BLANK = 2'd2
  } scan_state_e;

  // Segment masks in seg bit order {g,f,e,d,c,b,a}, active-high before inversion.
  localparam logic [6:0] SEG_A = 7'b000_0001;
  localparam logic [6:0] SEG_B = 7'b000_0010;
  localparam logic [6:0] SEG_C = 7'b000_0100;
  localparam logic [6:0] SEG_D = 7'b000_1000;
  localparam logic [6:0] SEG_E = 7'b001_0000;
  localparam logic [6:0] SEG_F = 7'b010_0000;
  localparam logic [6:0] SEG_G = 7'b100_0000;

  localparam logic [7:0] AN_ALL_OFF  = 8'hFF;
  localparam logic [6:0] SEG_ALL_OFF = 7'h7F;
  localparam logic       DP_OFF      = 1'b1;

endpackage

// File: rtl/display_scan_controller_hex7seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex7seg
  import display_scan_controller_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  logic [6:0] lit;

  always_comb begin
    lit = '0;
    case (nib_i)
      4'h0: lit = SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F;
      4'h1: lit = SEG_B | SEG_C;
      4'h2: lit = SEG_A | SEG_B | SEG_D | SEG_E | SEG_G;
      4'h3: lit = SEG_A | SEG_B | SEG_C | SEG_D | SEG_G;
      4'h4: lit = SEG_B | SEG_C | SEG_F | SEG_G;
      4'h5: lit = SEG_A | SEG_C | SEG_D | SEG_F | SEG_G;
      4'h6: lit = SEG_A | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;
      4'h7: lit = SEG_A | SEG_B | SEG_C;
      4'h8: lit = SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;
      4'h9: lit = SEG_A | SEG_B | SEG_C | SEG_D | SEG_F | SEG_G;
      4'hA: lit = SEG_A | SEG_B | SEG_C | SEG_E | SEG_F | SEG_G;
      4'hB: lit = SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;
      4'hC: lit = SEG_A | SEG_D | SEG_E | SEG_F;
      4'hD: lit = SEG_B | SEG_C | SEG_D | SEG_E | SEG_G;
      4'hE: lit = SEG_A | SEG_D | SEG_E | SEG_F | SEG_G;
      4'hF: lit = SEG_A | SEG_E | SEG_F | SEG_G;
      default: lit = '0;
    endcase
  end

  assign seg_o = ~lit;

endmodule

// File: rtl/display_scan_controller.sv
// Eight-digit multiplexed seven-segment scanner with double-buffered frames
// that only swap at frame wrap (or while dark), so a frame never tears.
module display_scan_controller
  import display_scan_controller_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 125000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] digits_in,
  input  logic [7:0]  dp_in,
  input  logic        load_valid,
  output logic        load_ready,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  localparam int unsigned T_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int TW = $clog2(T_MAX + 1);
  localparam logic [TW-1:0] DRIVE_LAST = TW'(REFRESH_DIV - 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYCLES - 1);

  scan_state_e   state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [31:0]   act_dig_q, act_dig_d, pend_dig_q, pend_dig_d;
  logic [7:0]    act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic          pend_q, pend_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          tick_q, tick_d;
  logic          wrap, commit, accept;
  logic [3:0]    nib;
  logic [6:0]    hex_seg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_OFF;
      idx_q      <= '0;
      timer_q    <= '0;
      act_dig_q  <= '0;
      act_dp_q   <= '0;
      pend_dig_q <= '0;
      pend_dp_q  <= '0;
      pend_q     <= 1'b0;
      an_q       <= AN_ALL_OFF;
      seg_q      <= SEG_ALL_OFF;
      dp_q       <= DP_OFF;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      timer_q    <= timer_d;
      act_dig_q  <= act_dig_d;
      act_dp_q   <= act_dp_d;
      pend_dig_q <= pend_dig_d;
      pend_dp_q  <= pend_dp_d;
      pend_q     <= pend_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      tick_q     <= tick_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    timer_d    = timer_q;
    act_dig_d  = act_dig_q;
    act_dp_d   = act_dp_q;
    pend_dig_d = pend_dig_q;
    pend_dp_d  = pend_dp_q;
    pend_d     = pend_q;
    wrap       = 1'b0;
    accept     = load_valid && !pend_q;

    if (!enable) begin
      state_d = ST_OFF;
      idx_d   = '0;
      timer_d = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d = ST_DRIVE;
          idx_d   = '0;
          timer_d = '0;
        end
        ST_DRIVE: begin
          if (timer_q == DRIVE_LAST) begin
            state_d = ST_BLANK;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        ST_BLANK: begin
          if (timer_q == BLANK_LAST) begin
            state_d = ST_DRIVE;
            timer_d = '0;
            idx_d   = idx_q + 3'd1;
            wrap    = (idx_q == 3'd7);
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        default: state_d = ST_OFF;
      endcase
    end

    // A dark display cannot tear, so a disable commits the pending frame too.
    commit = pend_q && (wrap || !enable);
    if (commit) begin
      act_dig_d = pend_dig_q;
      act_dp_d  = pend_dp_q;
      pend_d    = 1'b0;
    end
    if (accept) begin
      pend_dig_d = digits_in;
      pend_dp_d  = dp_in;
      pend_d     = 1'b1;
    end
  end

  // Outputs are decoded from the next state so they land with the state itself.
  assign nib = act_dig_d[{idx_d, 2'b00} +: 4];

  hex7seg u_hex7seg (
    .nib_i (nib),
    .seg_o (hex_seg)
  );

  always_comb begin
    an_d   = AN_ALL_OFF;
    seg_d  = SEG_ALL_OFF;
    dp_d   = DP_OFF;
    tick_d = wrap;
    if (state_d == ST_DRIVE) begin
      an_d  = ~(8'd1 << idx_d);
      seg_d = hex_seg;
      dp_d  = ~act_dp_d[idx_d];
    end
  end

  assign load_ready = !pend_q;
  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Self-checking bench: a frame-position model (slot arithmetic over a
// 48-cycle frame) predicts every output each cycle.
module tb_display_scan_controller;

  localparam int RD    = 4;
  localparam int BC    = 2;
  localparam int SLOT  = RD + BC;
  localparam int FRAME = 8 * SLOT;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] digits_in;
  logic [7:0]  dp_in;
  logic        load_valid;
  logic        load_ready;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  always #5 clk = ~clk;

  display_scan_controller #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Model: running flag, position within frame, active/pending frames.
  bit          m_run;
  int          m_ph;
  logic [39:0] m_act, m_pend;
  bit          m_pv;
  logic [17:0] exp_vec;
  logic [6:0]  seg_tab [16];

  wire [17:0] obs = {an, seg, dp, frame_tick, load_ready};
  localparam logic [17:0] ALL_OFF_VEC = {8'hFF, 7'h7F, 1'b1, 1'b0, 1'b1};

  function automatic logic [6:0] lit(string s);
    logic [6:0] r = 7'h7F;
    for (int i = 0; i < s.len(); i++) r[int'(s[i]) - 97] = 1'b0;
    return r;
  endfunction

  task automatic model_reset();
    m_run = 0; m_ph = 0; m_act = '0; m_pend = '0; m_pv = 0;
  endtask

  // Advance one clock, update the model from the sampled inputs, settle.
  task automatic cycle();
    logic [7:0] e_an;
    logic [6:0] e_seg;
    logic e_dp, e_ft, wrap, acc, com;
    int d;
    @(posedge clk);
    cyc++;
    wrap = m_run && enable && (m_ph == FRAME - 1);
    acc  = load_valid && !m_pv;
    com  = m_pv && (wrap || !enable);
    if (com) begin m_act = m_pend; m_pv = 0; end
    if (acc) begin m_pend = {dp_in, digits_in}; m_pv = 1; end
    if (!enable) m_run = 0;
    else if (!m_run) begin m_run = 1; m_ph = 0; end
    else m_ph = (m_ph + 1) % FRAME;
    e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_ft = wrap;
    if (m_run && (m_ph % SLOT) < RD) begin
      d     = m_ph / SLOT;
      e_an  = ~(8'd1 << d);
      e_seg = seg_tab[m_act[4*d +: 4]];
      e_dp  = ~m_act[32+d];
    end
    exp_vec = {e_an, e_seg, e_dp, e_ft, !m_pv};
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; load_valid = 1'b0; digits_in = '0; dp_in = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs !== ALL_OFF_VEC) begin
      errors++; $display("FAIL reset_hold got=%h exp=%h", obs, ALL_OFF_VEC);
    end
    @(negedge clk); reset = 1'b0;
    repeat (2) begin
      cycle();
      checks++;
      if (obs !== exp_vec) begin
        errors++; $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, obs, exp_vec);
      end
    end
  endtask

  task automatic test_scan();
    int last_tick = -1;
    int ticks = 0;
    digits_in = 32'h76543210; dp_in = 8'h02; load_valid = 1'b1; enable = 1'b1;
    cycle();
    checks++;
    if (an !== 8'hFE) begin
      errors++; $display("FAIL scan_start an got=%h exp=fe", an);
    end
    load_valid = 1'b0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      cycle();
      checks++;
      if (obs !== exp_vec) begin
        errors++; $display("FAIL scan cyc=%0d got=%h exp=%h", cyc, obs, exp_vec);
      end
      if (frame_tick === 1'b1) begin
        ticks++;
        if (last_tick >= 0) begin
          checks++;
          if (cyc - last_tick != FRAME) begin
            errors++; $display("FAIL scan_tick_period got=%0d exp=%0d", cyc - last_tick, FRAME);
          end
        end
        last_tick = cyc;
      end
    end
    checks++;
    if (ticks < 2) begin
      errors++; $display("FAIL scan_tick_count got=%0d exp>=2", ticks);
    end
  endtask

  task automatic test_back_to_back();
    bit found = 0;
    for (int i = 0; i < 2 * FRAME && !(m_run && m_ph / SLOT == 3); i++) cycle();
    digits_in = $urandom; dp_in = 8'($urandom); load_valid = 1'b1;
    cycle();
    checks++;
    if (obs !== exp_vec) begin
      errors++; $display("FAIL b2b_load cyc=%0d got=%h exp=%h", cyc, obs, exp_vec);
    end
    digits_in = $urandom; dp_in = 8'($urandom);
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      cycle();
      checks++;
      if (obs !== exp_vec) begin
        errors++; $display("FAIL b2b_hold cyc=%0d got=%h exp=%h", cyc, obs, exp_vec);
      end
      if (frame_tick === 1'b1) begin
        found = 1;
        checks++;
        if (load_ready !== 1'b1) begin
          errors++; $display("FAIL b2b_ready_at_wrap got=%b exp=1", load_ready);
        end
        cycle();
        checks++;
        if (load_ready !== 1'b0) begin
          errors++; $display("FAIL b2b_second_accept got=%b exp=0", load_ready);
        end
      end else begin
        checks++;
        if (load_ready !== 1'b0) begin
          errors++; $display("FAIL b2b_ready_before_wrap cyc=%0d got=%b exp=0", cyc, load_ready);
        end
      end
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL b2b_timeout got=no_wrap exp=wrap");
    end
    load_valid = 1'b0;
    for (int i = 0; i < FRAME + SLOT; i++) begin
      cycle();
      checks++;
      if (obs !== exp_vec) begin
        errors++; $display("FAIL b2b_after cyc=%0d got=%h exp=%h", cyc, obs, exp_vec);
      end
    end
  endtask

  task automatic test_disable();
    logic [31:0] cdig;
    logic [7:0]  cdp;
    for (int i = 0; i < 2 * FRAME && !(m_run && m_ph / SLOT == 5 && !m_pv); i++) cycle();
    cdig = $urandom; cdp = 8'($urandom);
    digits_in = cdig; dp_in = cdp; load_valid = 1'b1;
    cycle();
    load_valid = 1'b0; enable = 1'b0;
    cycle();
    checks++;
    if (an !== 8'hFF || load_ready !== 1'b1) begin
      errors++; $display("FAIL disable_dark an=%h rdy=%b exp an=ff rdy=1", an, load_ready);
    end
    repeat (3) begin
      cycle();
      checks++;
      if (obs !== exp_vec) begin
        errors++; $display("FAIL disable_idle cyc=%0d got=%h exp=%h", cyc, obs, exp_vec);
      end
    end
    enable = 1'b1;
    cycle();
    checks++;
    if (an !== 8'hFE || seg !== seg_tab[cdig[3:0]] || dp !== ~cdp[0]) begin
      errors++; $display("FAIL disable_restart an=%h seg=%h dp=%b exp an=fe seg=%h dp=%b",
                         an, seg, dp, seg_tab[cdig[3:0]], ~cdp[0]);
    end
    for (int i = 0; i < FRAME; i++) begin
      cycle();
      checks++;
      if (obs !== exp_vec) begin
        errors++; $display("FAIL disable_run cyc=%0d got=%h exp=%h", cyc, obs, exp_vec);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ready = 0;
    for (int i = 0; i < 2 * FRAME && !ready; i++) begin
      load_valid = !m_pv;
      digits_in = $urandom; dp_in = 8'($urandom);
      cycle();
      checks++;
      if (obs !== exp_vec) begin
        errors++; $display("FAIL rstmid_pre cyc=%0d got=%h exp=%h", cyc, obs, exp_vec);
      end
      ready = m_pv && m_run && (m_ph % SLOT) < RD && (m_ph % SLOT) > 0;
    end
    load_valid = 1'b0;
    checks++;
    if (!ready) begin
      errors++; $display("FAIL rstmid_setup got=not_ready exp=pending_in_drive");
    end
    #2 reset = 1'b1;
    #1;
    model_reset();
    checks++;
    if (obs !== ALL_OFF_VEC) begin
      errors++; $display("FAIL rstmid_dark got=%h exp=%h", obs, ALL_OFF_VEC);
    end
    @(negedge clk); reset = 1'b0;
    cycle();
    checks++;
    if (an !== 8'hFE || seg !== seg_tab[0] || dp !== 1'b1) begin
      errors++; $display("FAIL rstmid_zeros an=%h seg=%h dp=%b exp an=fe seg=%h dp=1", an, seg, dp, seg_tab[0]);
    end
    for (int i = 0; i < FRAME + SLOT; i++) begin
      cycle();
      checks++;
      if (obs !== exp_vec) begin
        errors++; $display("FAIL rstmid_run cyc=%0d got=%h exp=%h", cyc, obs, exp_vec);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 63) == 0) enable = ~enable;
      load_valid = ($urandom_range(0, 3) == 0);
      digits_in  = $urandom;
      dp_in      = 8'($urandom);
      cycle();
      checks++;
      if (obs !== exp_vec) begin
        errors++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs, exp_vec);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    seg_tab[0]  = lit("abcdef");  seg_tab[1]  = lit("bc");
    seg_tab[2]  = lit("abdeg");   seg_tab[3]  = lit("abcdg");
    seg_tab[4]  = lit("bcfg");    seg_tab[5]  = lit("acdfg");
    seg_tab[6]  = lit("acdefg");  seg_tab[7]  = lit("abc");
    seg_tab[8]  = lit("abcdefg"); seg_tab[9]  = lit("abcdfg");
    seg_tab[10] = lit("abcefg");  seg_tab[11] = lit("cdefg");
    seg_tab[12] = lit("adef");    seg_tab[13] = lit("bcdeg");
    seg_tab[14] = lit("adefg");   seg_tab[15] = lit("aefg");
    test_reset();
    test_scan();
    test_back_to_back();
    test_disable();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
